// File: rtl/eeprom_slave_rsp_if.sv
// Two-wire EEPROM bus bundle: master-driven SCL, resolved SDA level, slave open-drain pull-down.
interface eeprom_slave_rsp_if;
    logic SCL;
    logic SDA_IN;
    logic SDA_OE;

    modport slave (input SCL, input SDA_IN, output SDA_OE);
    modport master(output SCL, output SDA_IN, input SDA_OE);
endinterface

// File: rtl/eeprom_slave_rsp.sv
// Serial-EEPROM slave responder with internal 2^ADDR_W x 8 array.
// Optional write protect input WP is added when EEPROM_WP_EN is defined.
module eeprom_slave_rsp #(
    parameter int unsigned ADDR_W   = 11,
    parameter logic [3:0]  DEV_ID   = 4'b1010,
    parameter logic [7:0]  MEM_INIT = 8'hFF
) (
    input  logic               CLK,
    input  logic               RESET,
    eeprom_slave_rsp_if.slave  bus,
`ifdef EEPROM_WP_EN
    input  logic               WP,
`endif
    output logic               BUSY,
    output logic               WR_DONE
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE, S_CTRL, S_CTRL_ACK, S_ADDR, S_ADDR_ACK,
        S_WDATA, S_WDATA_ACK, S_RDATA, S_RACK
    } state_t;

    logic [1:0]        scl_sync_q, sda_sync_q;
    logic              scl_prev_q, sda_prev_q;
    logic              scl_s, sda_s, wp_s;
    logic              scl_rise, scl_fall, start_det, stop_det;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sda_oe_q, sda_oe_d;
    logic              wr_done_q;
    logic              mem_we;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        rd_byte;

    // Synchronizers reset to the idle-bus level so no false edge follows reset
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], bus.SCL};
            sda_sync_q <= {sda_sync_q[0], bus.SDA_IN};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

`ifdef EEPROM_WP_EN
    logic [1:0] wp_sync_q;
    always_ff @(posedge CLK) begin
        if (!RESET) wp_sync_q <= '0;
        else        wp_sync_q <= {wp_sync_q[0], WP};
    end
    assign wp_s = wp_sync_q[1];
`else
    assign wp_s = 1'b0;
`endif

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & ~sda_prev_q & sda_s;
    assign rd_byte   = mem_q[addr_q];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        addr_d   = addr_q;
        sda_oe_d = sda_oe_q;
        mem_we   = 1'b0;
        if (start_det) begin
            state_d  = S_CTRL;
            cnt_d    = '0;
            sda_oe_d = 1'b0;
        end else if (stop_det) begin
            state_d  = S_IDLE;
            sda_oe_d = 1'b0;
        end else begin
            case (state_q)
                S_CTRL, S_ADDR, S_WDATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_s};
                        cnt_d   = cnt_q + 1'b1;
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        cnt_d = '0;
                        if (state_q == S_CTRL) begin
                            if (shift_q[7:4] == DEV_ID) begin
                                state_d  = S_CTRL_ACK;
                                sda_oe_d = 1'b1;
                            end else begin
                                state_d  = S_IDLE;
                            end
                        end else if (state_q == S_ADDR) begin
                            addr_d[7:0] = shift_q;
                            state_d     = S_ADDR_ACK;
                            sda_oe_d    = 1'b1;
                        end else begin
                            state_d  = S_WDATA_ACK;
                            addr_d   = addr_q + 1'b1;
                            sda_oe_d = ~wp_s;
                            mem_we   = ~wp_s;
                        end
                    end
                end
                S_CTRL_ACK: begin
                    if (scl_fall) begin
                        cnt_d = '0;
                        if (shift_q[0]) begin
                            state_d  = S_RDATA;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            addr_d[ADDR_W-1:8] = shift_q[ADDR_W-8:1];
                            state_d  = S_ADDR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (scl_fall) begin
                        state_d  = S_WDATA;
                        sda_oe_d = 1'b0;
                    end
                end
                S_WDATA_ACK: begin
                    // A released ACK slot means the byte was NACKed (write protect)
                    if (scl_fall) begin
                        state_d  = sda_oe_q ? S_WDATA : S_IDLE;
                        sda_oe_d = 1'b0;
                    end
                end
                S_RDATA: begin
                    if (scl_fall) begin
                        if (cnt_q == 4'd7) begin
                            state_d  = S_RACK;
                            cnt_d    = '0;
                            sda_oe_d = 1'b0;
                            addr_d   = addr_q + 1'b1;
                        end else begin
                            sda_oe_d = ~rd_byte[3'(3'd6 - cnt_q[2:0])];
                            cnt_d    = cnt_q + 1'b1;
                        end
                    end
                end
                S_RACK: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_s};
                    end else if (scl_fall) begin
                        if (shift_q[0]) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d  = S_RDATA;
                            cnt_d    = '0;
                            sda_oe_d = ~rd_byte[7];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            addr_q    <= '0;
            sda_oe_q  <= 1'b0;
            wr_done_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            addr_q    <= addr_d;
            sda_oe_q  <= sda_oe_d;
            wr_done_q <= mem_we;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= MEM_INIT;
        end else if (mem_we) begin
            mem_q[addr_q] <= shift_q;
        end
    end

    assign bus.SDA_OE = sda_oe_q;
    assign BUSY       = (state_q != S_IDLE);
    assign WR_DONE    = wr_done_q;

endmodule

// File: tb/tb_eeprom_slave_rsp.sv
// Directed and randomized bench for eeprom_slave_rsp against an array-plus-pointer EEPROM model.
module tb_eeprom_slave_rsp;
    localparam int unsigned DEPTH = 2048;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic busy, wr_done;
    always #5 clk = ~clk;

    eeprom_slave_rsp_if bus();
    assign bus.SCL    = scl_m;
    assign bus.SDA_IN = sda_m & ~bus.SDA_OE;

`ifdef EEPROM_WP_EN
    logic wp = 1'b0;
`endif

    eeprom_slave_rsp #(.ADDR_W(11), .DEV_ID(4'b1010), .MEM_INIT(8'hFF)) dut (
        .CLK     (clk),
        .RESET   (rst_n),
        .bus     (bus),
`ifdef EEPROM_WP_EN
        .WP      (wp),
`endif
        .BUSY    (busy),
        .WR_DONE (wr_done)
    );

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int exp_wr = 0;
    logic [7:0] mem_m [DEPTH];
    int unsigned addr_m = 0;

    always @(negedge clk) if (wr_done === 1'b1) wr_cnt <= wr_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'hFF;
        addr_m = 0;
    endtask

    task automatic bstart();
        if (!scl_m) begin
            sda_m = 1'b1; wait_clk(3);
            scl_m = 1'b1; wait_clk(5);
        end
        sda_m = 1'b0; wait_clk(5);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic bstop();
        sda_m = 1'b0; wait_clk(3);
        scl_m = 1'b1; wait_clk(5);
        sda_m = 1'b1; wait_clk(6);
    endtask

    task automatic wbit(input logic b);
        sda_m = b; wait_clk(4);
        scl_m = 1'b1; wait_clk(6);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic rbit(output logic b);
        sda_m = 1'b1; wait_clk(4);
        scl_m = 1'b1; wait_clk(3);
        b = bus.SDA_IN; wait_clk(3);
        scl_m = 1'b0; wait_clk(2);
    endtask

    task automatic send_byte(input logic [7:0] d, output logic ack_n);
        for (int i = 7; i >= 0; i--) wbit(d[i]);
        rbit(ack_n);
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] d);
        for (int i = 7; i >= 0; i--) rbit(d[i]);
        wbit(nack);
    endtask

    function automatic logic [7:0] ctrl_byte(input int unsigned a, input logic rw);
        return {4'b1010, 3'((a >> 8) & 7), rw};
    endfunction

    task automatic wr_burst(input string tag, input int unsigned a, input int n,
                            input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic ack;
        logic [7:0] b;
        int unsigned pa;
        bstart();
        send_byte(ctrl_byte(a, 1'b0), ack); chk({tag, "/ctrl_ack"}, ack, 0);
        send_byte(8'(a), ack);              chk({tag, "/addr_ack"}, ack, 0);
        pa = a;
        for (int k = 0; k < n; k++) begin
            b = (k == 0) ? d0 : (k == 1) ? d1 : d2;
            send_byte(b, ack); chk({tag, "/data_ack"}, ack, 0);
            mem_m[pa] = b;
            pa = (pa + 1) % DEPTH;
            exp_wr++;
        end
        bstop();
        addr_m = pa;
        chk({tag, "/wr_done_count"}, wr_cnt, exp_wr);
        chk({tag, "/busy_after_stop"}, busy, 0);
    endtask

    task automatic read_bytes(input string tag, input int n);
        logic [7:0] d;
        for (int k = 0; k < n; k++) begin
            recv_byte(k == n - 1, d);
            chk({tag, "/rd_data"}, d, mem_m[addr_m]);
            addr_m = (addr_m + 1) % DEPTH;
        end
        bstop();
        chk({tag, "/busy_after_stop"}, busy, 0);
    endtask

    task automatic rd_random(input string tag, input int unsigned a, input int n);
        logic ack;
        bstart();
        send_byte(ctrl_byte(a, 1'b0), ack); chk({tag, "/ctrl_ack"}, ack, 0);
        send_byte(8'(a), ack);              chk({tag, "/addr_ack"}, ack, 0);
        addr_m = a;
        bstart();
        send_byte(ctrl_byte(0, 1'b1), ack); chk({tag, "/rctrl_ack"}, ack, 0);
        read_bytes(tag, n);
    endtask

    task automatic rd_current(input string tag, input int n);
        logic ack;
        bstart();
        send_byte(ctrl_byte(0, 1'b1), ack); chk({tag, "/rctrl_ack"}, ack, 0);
        read_bytes(tag, n);
    endtask

    initial begin
        logic ack;
        int unsigned a;
        int n, kind;
        model_reset();
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(3);
        chk("reset/busy", busy, 0);
        chk("reset/wr_done", wr_done, 0);
        chk("reset/sda_oe", bus.SDA_OE, 0);

        wr_burst("byte_write", 'h023, 1, 8'h5A, 8'h00, 8'h00);
        chk("byte_write/single_pulse", wr_cnt, 1);
        rd_random("byte_write_rd", 'h023, 1);

        wr_burst("rand_read_wr", 'h123, 1, 8'h5A, 8'h00, 8'h00);
        rd_random("rand_read", 'h123, 1);

        wr_burst("wrap_wr", 'h7FF, 2, 8'h11, 8'h22, 8'h00);
        chk("wrap/model_7ff", mem_m['h7FF], 8'h11);
        rd_random("wrap_rd", 'h7FF, 2);
        rd_current("wrap_cur", 1);

        // Wrong device ID: no ACK, rest of the frame ignored
        bstart();
        send_byte(8'hB0, ack);  chk("bad_id/nack", ack, 1);
        chk("bad_id/busy", busy, 0);
        send_byte(8'h23, ack);  chk("bad_id/ignored1", ack, 1);
        send_byte(8'h44, ack);  chk("bad_id/ignored2", ack, 1);
        bstop();
        chk("bad_id/no_write", wr_cnt, exp_wr);

        // STOP after four data bits
        bstart();
        send_byte(8'hA0, ack);  chk("abort_stop/ctrl_ack", ack, 0);
        send_byte(8'h40, ack);  chk("abort_stop/addr_ack", ack, 0);
        wbit(1'b1); wbit(1'b0); wbit(1'b1); wbit(1'b0);
        bstop();
        chk("abort_stop/no_write", wr_cnt, exp_wr);
        chk("abort_stop/busy", busy, 0);
        chk("abort_stop/sda_oe", bus.SDA_OE, 0);
        rd_random("abort_stop_rd", 'h040, 1);

        // RESET in the middle of the address byte
        bstart();
        send_byte(8'hA0, ack);  chk("abort_rst/ctrl_ack", ack, 0);
        wbit(1'b0); wbit(1'b1); wbit(1'b0); wbit(1'b1);
        rst_n = 1'b0;
        wait_clk(2);
        chk("abort_rst/busy", busy, 0);
        chk("abort_rst/sda_oe", bus.SDA_OE, 0);
        rst_n = 1'b1;
        model_reset();
        sda_m = 1'b0; wait_clk(3);
        scl_m = 1'b1; wait_clk(5);
        sda_m = 1'b1; wait_clk(6);
        chk("abort_rst/no_write", wr_cnt, exp_wr);
        rd_current("abort_rst_cur", 1);
        rd_random("abort_rst_init", 'h023, 1);
        wr_burst("abort_rst_next", 'h055, 1, 8'h3C, 8'h00, 8'h00);
        rd_random("abort_rst_next_rd", 'h055, 1);

        for (int r = 0; r < 24; r++) begin
            a    = $urandom_range(0, DEPTH - 1);
            n    = $urandom_range(1, 3);
            kind = $urandom_range(0, 2);
            if (kind == 0)
                wr_burst("rnd_wr", a, n, 8'($urandom), 8'($urandom), 8'($urandom));
            else if (kind == 1)
                rd_random("rnd_rd", a, n);
            else
                rd_current("rnd_cur", n);
        end

`ifdef EEPROM_WP_EN
        wp = 1'b1;
        wait_clk(4);
        bstart();
        send_byte(8'hA0, ack);  chk("wp/ctrl_ack", ack, 0);
        send_byte(8'h10, ack);  chk("wp/addr_ack", ack, 0);
        send_byte(8'h77, ack);  chk("wp/data_nack", ack, 1);
        bstop();
        chk("wp/no_write", wr_cnt, exp_wr);
        rd_random("wp_rd", 'h010, 1);
        wp = 1'b0;
        wait_clk(4);
        wr_burst("wp_retry", 'h010, 1, 8'h77, 8'h00, 8'h00);
        rd_random("wp_retry_rd", 'h010, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
